// File: rtl/com_host_pkg.sv
// com_host_pkg: shared types for the host-side com port initiator.
// Status codes are also decoded by the array's memory selector.
package com_host_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_READ = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    READ,
    FIN
  } state_t;

  function automatic status_t status_of(input state_t s);
    status_t r;
    r = ST_IDLE;
    unique case (s)
      LOAD:    r = ST_LOAD;
      RUN:     r = ST_RUN;
      READ:    r = ST_READ;
      default: r = ST_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/com_host_ctrl_rd_lat_pipe.sv
// rd_lat_pipe: flags the edge on which com_data_out holds the read data.
// Ports: clk, rst_n, issue (address presented this edge), hit (capture now).
module rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic hit
);

  logic [RD_LAT-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign hit = sr[RD_LAT-1];

endmodule

// File: rtl/com_host_ctrl.sv
// com_host_ctrl: loads a word stream into array DRAM, runs, reads results.
// Ports: start/busy/done/timeout_err, in_* load stream, out_* result stream, com_* DRAM port.
module com_host_ctrl
  import com_host_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE = 16'h0000,
  parameter int                LOAD_LEN  = 16,
  parameter logic [ADDR_W-1:0] RES_BASE  = 16'h0100,
  parameter int                RES_LEN   = 16,
  parameter int                RD_LAT    = 1,
  parameter int                SETTLE    = 2,
  parameter int                TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] com_data_in,
  output logic [ADDR_W-1:0] com_addr,
  output logic              com_wr_en,
  input  logic [DATA_W-1:0] com_data_out,
  input  logic              end_process
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LD_N = CW'(LOAD_LEN);
  localparam logic [CW-1:0] RS_N = CW'(RES_LEN);
  localparam logic [CW-1:0] ST_N = CW'(SETTLE);
  localparam logic [CW-1:0] TO_N = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam bit TO_EN  = TIMEOUT != 0;
  localparam bit HAS_LD = LOAD_LEN != 0;
  localparam bit HAS_RS = RES_LEN != 0;

  state_t state, state_n;
  logic [CW-1:0] idx, cnt, rd_next;
  logic ld_hs, rd_hs, issue, to_set, hit;

  // in_ready drops once all words are taken so the last write drains in LOAD
  assign in_ready = (state == LOAD) && (idx != LD_N);
  assign busy     = state != IDLE;
  assign done     = state == FIN;
  assign rd_next  = (state == RUN) ? '0 : idx + ONE;

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue),
    .hit   (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld_hs   = 1'b0;
    rd_hs   = 1'b0;
    issue   = 1'b0;
    to_set  = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = HAS_LD ? LOAD : RUN;
      LOAD: begin
        ld_hs = in_valid && in_ready;
        if (idx == LD_N) state_n = RUN;
      end
      RUN: begin
        // end_process has priority over a same-cycle timeout
        if (end_process && cnt >= ST_N) begin
          state_n = HAS_RS ? READ : FIN;
          issue   = HAS_RS;
        end else if (TO_EN && cnt == TO_N) begin
          state_n = FIN;
          to_set  = 1'b1;
        end
      end
      READ: begin
        rd_hs = out_valid && out_ready;
        if (rd_hs) begin
          if (idx + ONE == RS_N) state_n = FIN;
          else                   issue   = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status      <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      com_wr_en   <= 1'b0;
      com_addr    <= '0;
      com_data_in <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      status    <= status_of(state_n);
      com_wr_en <= ld_hs;
      // saturate so a long untimed run never re-enters the settle window
      if (state != RUN)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + ONE;
      if (state == IDLE && start) begin
        idx         <= '0;
        timeout_err <= 1'b0;
      end
      if (to_set) timeout_err <= 1'b1;
      if (ld_hs) begin
        idx         <= idx + ONE;
        com_addr    <= LOAD_BASE + idx[ADDR_W-1:0];
        com_data_in <= in_data;
      end
      if (issue) begin
        idx      <= rd_next;
        com_addr <= RES_BASE + rd_next[ADDR_W-1:0];
      end
      if (hit) begin
        out_data  <= com_data_out;
        out_valid <= 1'b1;
      end else if (rd_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_com_host_ctrl.sv
// tb_com_host_ctrl: randomized jobs against a job-level reference model.
// Memory returns addr^FFFF, valid from the first edge after the address.
module tb_com_host_ctrl;

  localparam logic [15:0] LB = 16'h0010;
  localparam int LL = 4;
  localparam logic [15:0] RB = 16'h0100;
  localparam int RL = 3;
  localparam int RDL = 1;
  localparam int STL = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic end_process = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, busy, done, timeout_err, com_wr_en;
  logic [15:0] out_data, com_data_in, com_addr, com_data_out;
  logic [1:0] status;

  always #5 clk = ~clk;

  assign com_data_out = com_addr ^ 16'hFFFF;

  com_host_ctrl #(
    .LOAD_BASE (LB),
    .LOAD_LEN  (LL),
    .RES_BASE  (RB),
    .RES_LEN   (RL),
    .RD_LAT    (RDL),
    .SETTLE    (STL),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .status       (status),
    .com_data_in  (com_data_in),
    .com_addr     (com_addr),
    .com_wr_en    (com_wr_en),
    .com_data_out (com_data_out),
    .end_process  (end_process)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // job-level model: phase 0 idle, 1 load, 2 last write, 3 run, 4 read, 5 done
  int ph, k, runc, lat;
  logic [15:0] e_addr, e_din, e_od;
  logic e_wr, e_ov, e_terr;
  logic [1:0] e_st;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; k = 0; runc = 0; lat = 0;
      e_addr = '0; e_din = '0; e_od = '0;
      e_wr = 1'b0; e_ov = 1'b0; e_terr = 1'b0; e_st = 2'b00;
    end else begin
      e_wr = 1'b0;
      case (ph)
        0: if (start) begin
          e_terr = 1'b0;
          k = 0;
          if (LL == 0) begin ph = 3; runc = 0; e_st = 2'b10; end
          else begin ph = 1; e_st = 2'b01; end
        end
        1: if (in_valid) begin
          e_wr = 1'b1;
          e_addr = LB + 16'(k);
          e_din = in_data;
          k++;
          if (k == LL) ph = 2;
        end
        2: begin ph = 3; runc = 0; e_st = 2'b10; end
        3: begin
          runc++;
          if (end_process && runc > STL) begin
            if (RL == 0) begin ph = 5; e_st = 2'b00; end
            else begin
              ph = 4; e_st = 2'b11; k = 0; e_addr = RB; lat = RDL;
            end
          end else if (TO != 0 && runc == TO) begin
            ph = 5; e_st = 2'b00; e_terr = 1'b1;
          end
        end
        4: if (e_ov && out_ready) begin
          e_ov = 1'b0;
          k++;
          if (k == RL) begin ph = 5; e_st = 2'b00; end
          else begin e_addr = RB + 16'(k); lat = RDL; end
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin e_ov = 1'b1; e_od = e_addr ^ 16'hFFFF; end
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("status", 16'(status), 16'(e_st));
    chk("busy", 16'(busy), 16'(ph != 0));
    chk("done", 16'(done), 16'(ph == 5));
    chk("timeout_err", 16'(timeout_err), 16'(e_terr));
    chk("in_ready", 16'(in_ready), 16'(ph == 1));
    chk("com_wr_en", 16'(com_wr_en), 16'(e_wr));
    chk("com_addr", com_addr, e_addr);
    chk("com_data_in", com_data_in, e_din);
    chk("out_valid", 16'(out_valid), 16'(e_ov));
    chk("out_data", out_data, e_od);
  end

  int ivm, orm, ep_at, jc, nhs, nout, stall, run_cyc;
  logic [15:0] base;
  bit noise, done_seen;
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic [15:0] outq[$];

  task automatic cyc();
    @(negedge clk);
    if (in_valid && in_ready) nhs++;
    if (out_valid && out_ready) begin outq.push_back(out_data); nout++; end
    if (com_wr_en) begin wa.push_back(com_addr); wd.push_back(com_data_in); end
    if (status == 2'b10) run_cyc++;
    if (done) done_seen = 1'b1;
    @(posedge clk);
    #1;
    jc++;
    case (ivm)
      0:       in_valid = 1'b1;
      1:       in_valid = ~in_valid;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_data = base + 16'(nhs);
    end_process = (ep_at >= 0) && (jc >= ep_at);
    case (orm)
      0: out_ready = 1'b1;
      1: if (out_valid && nout == 1 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    start = noise && busy && ($urandom_range(0, 3) == 0);
  endtask

  task automatic setup(input int iv, input int ep, input int orr,
                       input logic [15:0] b, input bit nz);
    ivm = iv; ep_at = ep; orm = orr; base = b; noise = nz;
    jc = 0; nhs = 0; nout = 0; stall = 0; run_cyc = 0;
    done_seen = 1'b0;
    wa.delete(); wd.delete(); outq.delete();
  endtask

  task automatic job(input int iv, input int ep, input int orr,
                     input logic [15:0] b, input bit nz);
    setup(iv, ep, orr, b, nz);
    start = 1'b1;
    in_valid = (iv == 0);
    end_process = (ep == 0);
    out_ready = 1'b1;
    cyc();
    while (!done_seen && jc < 300) cyc();
    chk("job_done", 16'(done_seen), 16'd1);
    cyc();
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_status", 16'(status), 16'd0);
    chk("rst_out_data", out_data, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // in_valid held, end_process high from the start, stall on word 2
    job(0, 0, 1, 16'h00A1, 1'b0);
    chk("j1_nwr", 16'(wa.size()), 16'd4);
    chk("j1_w0_addr", wa[0], 16'h0010);
    chk("j1_w0_data", wd[0], 16'h00A1);
    chk("j1_w3_addr", wa[3], 16'h0013);
    chk("j1_w3_data", wd[3], 16'h00A4);
    chk("j1_run_cycles", 16'(run_cyc), 16'd3);
    chk("j1_nout", 16'(outq.size()), 16'd3);
    chk("j1_out0", outq[0], 16'hFEFF);
    chk("j1_out1", outq[1], 16'hFEFE);
    chk("j1_out2", outq[2], 16'hFEFD);

    // toggling in_valid: one write per handshake, no gaps or repeats
    job(1, 12, 2, 16'h0B00, 1'b0);
    chk("j2_nwr", 16'(wa.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk("j2_addr", wa[i], 16'h0010 + 16'(i));
      chk("j2_data", wd[i], 16'h0B00 + 16'(i));
    end

    // no end_process: timeout after 20 RUN cycles, no readout
    job(0, -1, 0, 16'h0C00, 1'b0);
    chk("j3_run_cycles", 16'(run_cyc), 16'd20);
    chk("j3_nout", 16'(outq.size()), 16'd0);
    chk("j3_terr", 16'(timeout_err), 16'd1);

    // restart clears timeout_err; reset mid-load after two writes
    setup(0, -1, 0, 16'h0D00, 1'b0);
    start = 1'b1;
    in_valid = 1'b1;
    cyc();
    chk("j4_terr_clr", 16'(timeout_err), 16'd0);
    while (wa.size() < 2 && jc < 20) cyc();
    chk("j4_two_writes", 16'(wa.size()), 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_status", 16'(status), 16'd0);
    chk("ar_busy", 16'(busy), 16'd0);
    chk("ar_wr_en", 16'(com_wr_en), 16'd0);
    chk("ar_addr", com_addr, 16'd0);
    chk("ar_data_in", com_data_in, 16'd0);
    chk("ar_in_ready", 16'(in_ready), 16'd0);
    chk("ar_out_valid", 16'(out_valid), 16'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    job(0, 3, 0, 16'h0E00, 1'b0);
    chk("j5_w0_addr", wa[0], 16'h0010);
    chk("j5_w0_data", wd[0], 16'h0E00);
    chk("j5_nout", 16'(outq.size()), 16'd3);

    // random traffic, random end_process timing, stray starts while busy
    for (int j = 0; j < 12; j++)
      job(2, int'($urandom_range(0, 28)), 2, 16'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
